// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input conditioner: joystick bit map,
// coin FSM states and width helpers.
package arcade_input_pkg;

  localparam int unsigned JB_RIGHT  = 0;
  localparam int unsigned JB_LEFT   = 1;
  localparam int unsigned JB_DOWN   = 2;
  localparam int unsigned JB_UP     = 3;
  localparam int unsigned JB_TRIG1  = 4;
  localparam int unsigned JB_TRIG2  = 5;
  localparam int unsigned JB_START1 = 6;
  localparam int unsigned JB_START2 = 7;
  localparam int unsigned JB_COIN   = 8;
  localparam int unsigned JB_PAUSE  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

  // Width of the 1 ms tick divider counter.
  function automatic int unsigned tick_width(input int unsigned clk_hz);
    int unsigned div;
    div = clk_hz / 1000;
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Width of a ms-tick timer able to hold the largest of three durations.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/arcade_coin_pulser.sv
// One coin channel: press edge detect, saturating credit queue and a
// fixed-width pulse/gap FSM timed in ms ticks.
module arcade_coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int unsigned COIN_MS = 50,
  parameter int unsigned GAP_MS  = 50,
  parameter int unsigned QDEPTH  = 3,
  parameter int unsigned TW      = 6
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic tick,
  input  logic pause,
  input  logic coin_raw,
  output logic coin
);

  localparam int unsigned QW = $clog2(QDEPTH + 1);

  coin_state_t   state;
  logic [TW-1:0] timer;
  logic [QW-1:0] credits;
  logic          raw_q;
  logic          edge_c;
  logic          deq_c;

  assign edge_c = coin_raw & ~raw_q;
  assign deq_c  = (state == IDLE) && (credits != '0) && !pause;

  // Credit queue: a simultaneous press and dequeue leaves the count unchanged.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      raw_q   <= 1'b0;
      credits <= '0;
    end else begin
      raw_q <= coin_raw;
      if (edge_c && !deq_c) begin
        if (credits != QW'(QDEPTH)) credits <= credits + QW'(1);
      end else if (!edge_c && deq_c) begin
        credits <= credits - QW'(1);
      end
    end
  end

  // Pause only blocks leaving IDLE; a started pulse and its gap always finish.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
      coin  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (deq_c) begin
            state <= PULSE;
            timer <= '0;
            coin  <= 1'b1;
          end
        end
        PULSE: begin
          if (tick) begin
            if (timer == TW'(COIN_MS - 1)) begin
              state <= GAP;
              timer <= '0;
              coin  <= 1'b0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (timer == TW'(GAP_MS - 1)) begin
              state <= IDLE;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          coin  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arcade_input_cond.sv
// Conditions raw joystick words into registered INP0/INP1/INP2 game inputs.
// Optional autofire on trig1 when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_cond
  import arcade_input_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 48000000,
  parameter int unsigned COIN_MS     = 50,
  parameter int unsigned GAP_MS      = 50,
  parameter int unsigned QDEPTH      = 3,
  parameter int unsigned AUTOFIRE_MS = 33
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  input  logic        dual_controls,
  input  logic        ext_pause,
  input  logic        autofire_on,
  output logic [5:0]  inp0,
  output logic [5:0]  inp1,
  output logic [3:0]  inp2,
  output logic        pause_toggle,
  output logic        pause
);

  localparam int unsigned DIV = CLK_HZ / 1000;
  localparam int unsigned CW  = tick_width(CLK_HZ);
  localparam int unsigned TW  = timer_width(COIN_MS, GAP_MS, AUTOFIRE_MS);

  logic [CW-1:0] tick_cnt;
  logic          tick_c;
  logic [5:0]    d1_c, d2_c, p1_c, p2_c;
  logic [1:0]    trig1_c;
  logic [1:0]    start_q;
  logic [1:0]    coin;
  logic          pb_c, pb_q, toggle_next_c, pause_c;
  logic          unused_c;

  // Free-running 1 ms tick; keeps counting through pause.
  assign tick_c = (tick_cnt == CW'(DIV - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) tick_cnt <= '0;
    else if (tick_c) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + CW'(1);
  end

  assign d1_c = {joy1[JB_TRIG2], joy1[JB_TRIG1], joy1[JB_LEFT],
                 joy1[JB_DOWN], joy1[JB_RIGHT], joy1[JB_UP]};
  assign d2_c = {joy2[JB_TRIG2], joy2[JB_TRIG1], joy2[JB_LEFT],
                 joy2[JB_DOWN], joy2[JB_RIGHT], joy2[JB_UP]};
  assign p1_c = d1_c | (dual_controls ? 6'd0 : d2_c);
  assign p2_c = d2_c | (dual_controls ? 6'd0 : d1_c);

  // Pause button toggles once per press of either stick.
  assign pb_c          = joy1[JB_PAUSE] | joy2[JB_PAUSE];
  assign toggle_next_c = pause_toggle ^ (pb_c & ~pb_q);
  assign pause_c       = pause_toggle | ext_pause;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic [1:0]    af_src_c, af_edge_c, af_held, af_phase;
  logic [TW-1:0] af_timer [2];

  assign af_src_c  = {p2_c[4], p1_c[4]};
  assign af_edge_c = af_src_c & ~af_held;
  assign trig1_c   = af_src_c & ({2{~autofire_on}} | af_edge_c | af_phase);
  assign unused_c  = ^{joy1[15:10], joy2[15:10]};

  // Square wave per trigger, restarted high on every press edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_held  <= '0;
      af_phase <= '0;
      for (int i = 0; i < 2; i++) af_timer[i] <= '0;
    end else begin
      af_held <= af_src_c;
      for (int i = 0; i < 2; i++) begin
        if (af_edge_c[i]) begin
          af_phase[i] <= 1'b1;
          af_timer[i] <= '0;
        end else if (af_src_c[i] && tick_c) begin
          if (af_timer[i] == TW'(AUTOFIRE_MS - 1)) begin
            af_timer[i] <= '0;
            af_phase[i] <= ~af_phase[i];
          end else begin
            af_timer[i] <= af_timer[i] + TW'(1);
          end
        end
      end
    end
  end
`else
  assign trig1_c  = {p2_c[4], p1_c[4]};
  assign unused_c = ^{joy1[15:10], joy2[15:10], autofire_on};
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      inp0         <= '0;
      inp1         <= '0;
      start_q      <= '0;
      pb_q         <= 1'b0;
      pause_toggle <= 1'b0;
      pause        <= 1'b0;
    end else begin
      inp0         <= {p1_c[5], trig1_c[0], p1_c[3:0]};
      inp1         <= {p2_c[5], trig1_c[1], p2_c[3:0]};
      start_q      <= {joy1[JB_START2] | joy2[JB_START1],
                       joy1[JB_START1] | joy2[JB_START2]};
      pb_q         <= pb_c;
      pause_toggle <= toggle_next_c;
      pause        <= toggle_next_c | ext_pause;
    end
  end

  // Coin bits come straight from the pulser registers to keep pulse timing exact.
  assign inp2 = {coin[1], coin[0], start_q};

  arcade_coin_pulser #(
    .COIN_MS (COIN_MS),
    .GAP_MS  (GAP_MS),
    .QDEPTH  (QDEPTH),
    .TW      (TW)
  ) u_coin1 (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .tick     (tick_c),
    .pause    (pause_c),
    .coin_raw (joy1[JB_COIN]),
    .coin     (coin[0])
  );

  arcade_coin_pulser #(
    .COIN_MS (COIN_MS),
    .GAP_MS  (GAP_MS),
    .QDEPTH  (QDEPTH),
    .TW      (TW)
  ) u_coin2 (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .tick     (tick_c),
    .pause    (pause_c),
    .coin_raw (joy2[JB_COIN]),
    .coin     (coin[1])
  );

endmodule
